// File: rtl/conv_window_driver.sv
// 3x3 convolution sequencer: latches a pixel window and kernel, streams the nine
// taps into an external saturating MAC, then maps the MAC sum to an 8-bit pixel.
module conv_window_driver #(
  parameter bit ABS_MODE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [71:0] window,
  input  logic [71:0] kernel,
  output logic        busy,
  output logic [7:0]  pixel_out,
  output logic        out_valid,
  output logic        protocol_error,
  output logic        mac_clear,
  output logic        mac_enable,
  output logic [7:0]  mac_value_a,
  output logic [7:0]  mac_value_b,
  input  logic [8:0]  mac_result,
  input  logic        mac_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t      state_q;
  logic [3:0]  tap_q;
  logic [3:0]  tap_nxt;
  logic [71:0] win_q;
  logic [71:0] ker_q;
  logic        busy_q;
  logic [7:0]  pixel_q;
  logic        valid_q;
  logic        perr_q;
  logic        clr_q;
  logic        en_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [8:0]  mag;
  logic [7:0]  pixel_d;

  assign tap_nxt = tap_q + 4'd1;

  // Negating in 9 bits turns -256 into 9'h100; bit 8 then flags the clamp case.
  always_comb begin
    mag     = 9'd0 - mac_result;
    pixel_d = mac_result[7:0];
    if (mac_result[8]) begin
      if (ABS_MODE) pixel_d = mag[8] ? 8'hFF : mag[7:0];
      else          pixel_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      win_q   <= '0;
      ker_q   <= '0;
      busy_q  <= 1'b0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            win_q   <= window;
            ker_q   <= kernel;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
            tap_q   <= '0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          clr_q   <= 1'b0;
          en_q    <= 1'b1;
          a_q     <= win_q[7:0];
          b_q     <= ker_q[7:0];
          tap_q   <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          if (!mac_done) perr_q <= 1'b1;
          if (tap_q == 4'd8) begin
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            state_q <= DRAIN;
          end else begin
            tap_q <= tap_nxt;
            a_q   <= win_q[8*tap_nxt +: 8];
            b_q   <= ker_q[8*tap_nxt +: 8];
          end
        end
        DRAIN: begin
          if (!mac_done) perr_q <= 1'b1;
          pixel_q <= pixel_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          tap_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign pixel_out      = pixel_q;
  assign out_valid      = valid_q;
  assign protocol_error = perr_q;
  assign mac_clear      = clr_q;
  assign mac_enable     = en_q;
  assign mac_value_a    = a_q;
  assign mac_value_b    = b_q;

endmodule

// File: tb/tb_conv_window_driver.sv
// Directed bench: two drivers (ABS_MODE 1 and 0) each paired with a saturating MAC model.
module tb_conv_window_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [71:0] window;
  logic [71:0] kernel;

  logic       busy_a, ov_a, perr_a, clr_a, en_a, done_a;
  logic [7:0] pix_a, va_a, vb_a;
  logic [8:0] res_a;
  logic       busy_c, ov_c, perr_c, clr_c, en_c, done_c;
  logic [7:0] pix_c, va_c, vb_c;
  logic [8:0] res_c;

  int acc_a = 0;
  int acc_c = 0;
  bit hold_done = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  conv_window_driver #(.ABS_MODE(1'b1)) u_abs (
    .clock(clock), .reset(reset), .start(start), .window(window), .kernel(kernel),
    .busy(busy_a), .pixel_out(pix_a), .out_valid(ov_a), .protocol_error(perr_a),
    .mac_clear(clr_a), .mac_enable(en_a), .mac_value_a(va_a), .mac_value_b(vb_a),
    .mac_result(res_a), .mac_done(done_a)
  );

  conv_window_driver #(.ABS_MODE(1'b0)) u_clip (
    .clock(clock), .reset(reset), .start(start), .window(window), .kernel(kernel),
    .busy(busy_c), .pixel_out(pix_c), .out_valid(ov_c), .protocol_error(perr_c),
    .mac_clear(clr_c), .mac_enable(en_c), .mac_value_a(va_c), .mac_value_b(vb_c),
    .mac_result(res_c), .mac_done(done_c)
  );

  function automatic int sat(input int v);
    if (v > 255)  return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  // MAC models: saturate after every accumulate, ack one cycle after clear/enable.
  always @(posedge clock) begin
    if (clr_a)     acc_a <= 0;
    else if (en_a) acc_a <= sat(acc_a + int'(va_a) * int'($signed(vb_a)));
    done_a <= (clr_a | en_a) & ~hold_done;
  end
  always @(posedge clock) begin
    if (clr_c)     acc_c <= 0;
    else if (en_c) acc_c <= sat(acc_c + int'(va_c) * int'($signed(vb_c)));
    done_c <= (clr_c | en_c) & ~hold_done;
  end
  assign res_a = acc_a[8:0];
  assign res_c = acc_c[8:0];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a job with start, then scramble the inputs once it has been accepted.
  task automatic kick(input logic [71:0] w, input logic [71:0] k);
    window = w;
    kernel = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
    window = ~w;
    kernel = ~k;
  endtask

  // j counts samples after the accepting edge; ends on the out_valid cycle.
  task automatic track(input logic [71:0] w, input logic [71:0] k,
                       input int e_abs, input int e_clip, input bit mid, input int e_perr);
    for (int j = 0; j <= 11; j++) begin
      if (j == 0) begin
        check("clear_cycle", clr_a, 1);
        check("clear_no_en", en_a, 0);
        check("busy_start", busy_a, 1);
      end else if (j <= 9) begin
        check("accum_en", en_a, 1);
        check("accum_no_clr", clr_a, 0);
        check("tap_pixel", va_a, int'(w[8*(j-1) +: 8]));
        check("tap_coef", vb_a, int'(k[8*(j-1) +: 8]));
      end else if (j == 10) begin
        check("drain_en", en_a, 0);
        check("drain_a", va_a, 0);
        check("drain_b", vb_a, 0);
        check("drain_valid", ov_a, 0);
        check("drain_busy", busy_a, 1);
      end else begin
        check("valid_abs", ov_a, 1);
        check("valid_clip", ov_c, 1);
        check("done_busy", busy_a, 0);
        check("pixel_abs", pix_a, e_abs);
        check("pixel_clip", pix_c, e_clip);
        check("perr", perr_a, e_perr);
      end
      if (mid && j == 5) start = 1'b1;
      if (mid && j == 6) start = 1'b0;
      if (j < 11) step();
    end
  endtask

  task automatic idle_check(input int e_abs, input int e_clip);
    step();
    check("idle_valid", ov_a, 0);
    check("idle_busy", busy_a, 0);
    check("hold_abs", pix_a, e_abs);
    check("hold_clip", pix_c, e_clip);
  endtask

  logic [71:0] flat, left0, left200, gx, w1, k1, kneg, wid, kid;
  int pulses;

  initial begin
    flat    = {9{8'd100}};
    left0   = {8'd200, 8'd200, 8'd0, 8'd200, 8'd200, 8'd0, 8'd200, 8'd200, 8'd0};
    left200 = {8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200};
    gx      = {8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF};
    w1      = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    k1      = {8'h01, 8'hFF, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h03, 8'hFE, 8'h01};
    kneg    = {9{8'hFF}};
    wid     = {8'd99, 8'd99, 8'd99, 8'd99, 8'd37, 8'd99, 8'd99, 8'd99, 8'd99};
    kid     = {32'h0, 8'h01, 32'h0};

    reset = 1'b1; start = 1'b0; window = '0; kernel = '0;
    step(); step();
    check("rst_busy", busy_a, 0);
    check("rst_valid", ov_a, 0);
    check("rst_pixel", pix_a, 0);
    check("rst_perr", perr_a, 0);
    check("rst_clr", clr_a, 0);
    check("rst_en", en_a, 0);
    check("rst_a", va_a, 0);
    check("rst_b", vb_a, 0);

    // Reset wins over a simultaneous start.
    window = flat; kernel = gx; start = 1'b1;
    step();
    check("rst_prio_busy", busy_a, 0);
    check("rst_prio_clr", clr_a, 0);
    start = 1'b0; reset = 1'b0;
    step();

    kick(flat, gx);    track(flat, gx, 0, 0, 1'b0, 0);       idle_check(0, 0);
    kick(left0, gx);   track(left0, gx, 255, 255, 1'b0, 0);  idle_check(255, 255);
    kick(left200, gx); track(left200, gx, 255, 0, 1'b1, 0);  idle_check(255, 0);

    // Mid-job start ignored, then back-to-back job started on the out_valid cycle.
    kick(w1, k1);   track(w1, k1, 23, 23, 1'b1, 0);
    kick(w1, kneg); track(w1, kneg, 45, 0, 1'b0, 0);
    idle_check(45, 0);

    // Abort while tap 4 is on the bus.
    kick(w1, k1);
    repeat (5) step();
    check("abort_tap4", va_a, 5);
    reset = 1'b1;
    step();
    check("abort_busy", busy_a, 0);
    check("abort_valid", ov_a, 0);
    check("abort_pixel", pix_a, 0);
    check("abort_en", en_a, 0);
    check("abort_clr", clr_a, 0);
    check("abort_a", va_a, 0);
    check("abort_b", vb_a, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ov_a || ov_c) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    kick(wid, kid); track(wid, kid, 37, 37, 1'b0, 0); idle_check(37, 37);

    // Missing MAC ack: error sets, job completes, error stays until reset.
    hold_done = 1'b1;
    kick(w1, k1); track(w1, k1, 23, 23, 1'b0, 1);
    hold_done = 1'b0;
    idle_check(23, 23);
    kick(w1, kneg); track(w1, kneg, 45, 0, 1'b0, 1);
    reset = 1'b1;
    step();
    check("perr_cleared", perr_a, 0);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
